// File: rtl/klingon_scan_ctrl.sv
// Time-multiplexes NUM_DIGITS Klingon digits onto one shared 7-seg glyph decoder, blanking between digits.
// Latency: all outputs registered; a load reaches the display at the next frame boundary (or one cycle later when idle).
// Backpressure: load_ready drops for the cycle after a capture and stays low until the pending word is committed.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   enable             1 = scanning, 0 = display off (IDLE)
//   load_valid/_data   producer word, digit i = load_data[4i+3:4i], digit 0 rightmost
//   load_ready         pending buffer empty, a load offered now is accepted
//   code               4-bit code to the glyph decoder, 4'hF = blank
//   digit_sel          one-hot digit enable, all zero while blanked
//   scan_idx           index of the digit owning the current slot
//   frame_done         one-cycle pulse after the last digit's drive slot ends
module klingon_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          load_valid,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  output logic                          load_ready,
  output logic [3:0]                    code,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int DW   = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] active, active_n;
  logic [DW-1:0] pend_dat, pend_dat_n;
  logic          pend_vld, pend_vld_n;
  logic          frame_done_n;

  logic [3:0]            code_n;
  logic [NUM_DIGITS-1:0] digit_sel_n;

  logic capture;
  logic blank_last;
  logic drive_last;
  logic idx_last;

  assign capture    = load_valid & load_ready;
  assign blank_last = (cnt == CW'(BLANK_CYCLES - 1));
  assign drive_last = (cnt == CW'(DWELL_CYCLES - 1));
  assign idx_last   = (idx == IW'(NUM_DIGITS - 1));

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      active     <= '1;
      pend_dat   <= '0;
      pend_vld   <= 1'b0;
      load_ready <= 1'b1;
      code       <= 4'hF;
      digit_sel  <= '0;
      scan_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      active     <= active_n;
      pend_dat   <= pend_dat_n;
      pend_vld   <= pend_vld_n;
      load_ready <= ~pend_vld_n;
      code       <= code_n;
      digit_sel  <= digit_sel_n;
      scan_idx   <= idx_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state, buffer and counter logic.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    active_n     = active;
    pend_dat_n   = pend_dat;
    pend_vld_n   = pend_vld;
    frame_done_n = 1'b0;

    case (state)
      IDLE: begin
        idx_n = '0;
        cnt_n = '0;
        // Nothing is on screen, so a pending word can go live immediately.
        if (pend_vld) begin
          active_n   = pend_dat;
          pend_vld_n = 1'b0;
        end
        if (enable) begin
          state_n = BLANK;
        end
      end

      BLANK: begin
        if (!enable) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (blank_last) begin
          state_n = DRIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DRIVE: begin
        if (!enable) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (drive_last) begin
          state_n = BLANK;
          cnt_n   = '0;
          if (idx_last) begin
            // Frame boundary: the only point mid-scan where the active word may change.
            idx_n        = '0;
            frame_done_n = 1'b1;
            if (pend_vld) begin
              active_n   = pend_dat;
              pend_vld_n = 1'b0;
            end
          end else begin
            idx_n = idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase

    // load_ready is only high when pending is empty, so capture never collides with a commit.
    if (capture) begin
      pend_dat_n = load_data;
      pend_vld_n = 1'b1;
    end
  end

  // Output decode from next state so the registered outputs line up with the state register.
  always_comb begin
    code_n      = 4'hF;
    digit_sel_n = '0;
    if (state_n == DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_n == IW'(i)) begin
          code_n = active_n[4*i +: 4];
        end
      end
      digit_sel_n[idx_n] = 1'b1;
    end
  end

endmodule
